// File: rtl/acondicionador_senal_pkg.sv
// acondicionador_senal_pkg: filter state encodings and default parameter values shared by the conditioner blocks
`timescale 1ns/1ps
package acondicionador_senal_pkg;
  typedef enum logic [1:0] {
    BAJO      = 2'd0,
    VERIF_SUB = 2'd1,
    ALTO      = 2'd2,
    VERIF_BAJ = 2'd3
  } estado_t;
  localparam int N_SYNC_DEF   = 2;
  localparam int N_FILTRO_DEF = 4;
  localparam int TIMEOUT_DEF  = 50000;
endpackage

// File: rtl/acondicionador_senal_sincronizador.sv
// sincronizador: generic N-flop synchroniser for asynchronous single-bit inputs
`timescale 1ns/1ps
module sincronizador #(
  parameter int N_SYNC = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [N_SYNC-1:0] ff;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ff <= '0;
    else ff <= {ff[N_SYNC-2:0], d};
  assign q = ff[N_SYNC-1];
endmodule

// File: rtl/acondicionador_senal.sv
// acondicionador_senal: synchronises and deglitches a raw input, emits edge strobes and a loss-of-signal flag
`timescale 1ns/1ps
module acondicionador_senal
  import acondicionador_senal_pkg::*;
#(
  parameter int N_SYNC         = N_SYNC_DEF,
  parameter int N_FILTRO       = N_FILTRO_DEF,
  parameter int TIMEOUT_CICLOS = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_signal,
  output logic o_signal,
  output logic o_flanco_sub,
  output logic o_flanco_baj,
  output logic o_sin_senal
);
  localparam int CW = $clog2(N_FILTRO) + 1;
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic s;
  estado_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic sig_n, sub_n, baj_n, sin_n, acc;
  sincronizador #(.N_SYNC(N_SYNC)) u_sync (
    .clock(clock),
    .reset_n(reset_n),
    .d(i_signal),
    .q(s)
  );
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    sig_n = o_signal;
    sub_n = 1'b0;
    baj_n = 1'b0;
    case (st)
      BAJO:
        if (s) begin
          st_n  = VERIF_SUB;
          cnt_n = CW'(1);
        end
      VERIF_SUB:
        if (!s) st_n = BAJO;
        else if (cnt == CW'(N_FILTRO - 1)) begin
          st_n  = ALTO;
          sig_n = 1'b1;
          sub_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      ALTO:
        if (!s) begin
          st_n  = VERIF_BAJ;
          cnt_n = CW'(1);
        end
      VERIF_BAJ:
        if (s) st_n = ALTO;
        else if (cnt == CW'(N_FILTRO - 1)) begin
          st_n  = BAJO;
          sig_n = 1'b0;
          baj_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
    endcase
    // Timeout saturates at TIMEOUT_CICLOS, so the flag stays set until an edge clears the count
    acc    = sub_n | baj_n;
    tcnt_n = acc ? '0 : (tcnt == TW'(TIMEOUT_CICLOS) ? tcnt : tcnt + 1'b1);
    sin_n  = !acc && tcnt_n == TW'(TIMEOUT_CICLOS);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st           <= BAJO;
      cnt          <= '0;
      tcnt         <= '0;
      o_signal     <= 1'b0;
      o_flanco_sub <= 1'b0;
      o_flanco_baj <= 1'b0;
      o_sin_senal  <= 1'b0;
    end else begin
      st           <= st_n;
      cnt          <= cnt_n;
      tcnt         <= tcnt_n;
      o_signal     <= sig_n;
      o_flanco_sub <= sub_n;
      o_flanco_baj <= baj_n;
      o_sin_senal  <= sin_n;
    end
endmodule

// File: tb/tb_acondicionador_senal.sv
// tb_acondicionador_senal: scoreboard bench, expected strobes queued at stimulus time and matched by a monitor
`timescale 1ns/1ps
module tb_acondicionador_senal;
  localparam int T   = 100;
  localparam int LAT = 6;
  logic clock = 1'b0, reset_n = 1'b0, i_signal = 1'b0;
  logic o_signal, o_flanco_sub, o_flanco_baj, o_sin_senal;
  typedef struct {logic rise; int cyc;} exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, errors = 0, last_acc = 0;

  acondicionador_senal #(.N_SYNC(2), .N_FILTRO(4), .TIMEOUT_CICLOS(T)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .i_signal(i_signal),
    .o_signal(o_signal),
    .o_flanco_sub(o_flanco_sub),
    .o_flanco_baj(o_flanco_baj),
    .o_sin_senal(o_sin_senal)
  );

  always #20 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard; overdue entries are misses
  always @(negedge clock) begin
    if (o_flanco_sub || o_flanco_baj) begin
      checks++;
      if (o_flanco_sub && o_flanco_baj) begin
        errors++;
        $display("FAIL strobe_both cyc=%0d sub=%b baj=%b required one-hot", cyc, o_flanco_sub, o_flanco_baj);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected cyc=%0d sub=%b baj=%b required none", cyc, o_flanco_sub, o_flanco_baj);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_flanco_sub !== e.rise || cyc !== e.cyc || o_signal !== e.rise || o_sin_senal !== 1'b0) begin
          errors++;
          $display("FAIL strobe_match got sub=%b cyc=%0d sig=%b sin=%b required sub=%b cyc=%0d sig=%b sin=0",
                   o_flanco_sub, cyc, o_signal, o_sin_senal, e.rise, e.cyc, e.rise);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL strobe_missing cyc=%0d got none required sub=%b at cyc=%0d", cyc, e.rise, e.cyc);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic drive(input logic v);
    i_signal = v;
    sb.push_back('{v, cyc + LAT});
    last_acc = cyc + LAT;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #90;
    checks++;
    if ({o_signal, o_flanco_sub, o_flanco_baj, o_sin_senal} !== 4'b0) begin
      errors++;
      $display("FAIL reset_hold got %b required 0000", {o_signal, o_flanco_sub, o_flanco_baj, o_sin_senal});
    end
    #10;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if ({o_signal, o_flanco_sub, o_flanco_baj, o_sin_senal} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release got %b required 0000", {o_signal, o_flanco_sub, o_flanco_baj, o_sin_senal});
    end
  endtask

  task automatic test_edge(input logic v);
    int t0;
    bit ok;
    t0 = cyc;
    drive(v);
    wait_cyc(t0 + LAT - 1);
    checks++;
    if (o_signal !== !v) begin
      errors++;
      $display("FAIL edge_early lvl=%b got o_signal=%b required %b", v, o_signal, !v);
    end
    wait_cyc(t0 + LAT);
    checks++;
    if (o_signal !== v) begin
      errors++;
      $display("FAIL edge_latency lvl=%b got o_signal=%b required %b", v, o_signal, v);
    end
    step();
    checks++;
    if ({o_flanco_sub, o_flanco_baj} !== 2'b00 || o_signal !== v) begin
      errors++;
      $display("FAIL edge_after lvl=%b got strobes=%b sig=%b required 00 %b", v, {o_flanco_sub, o_flanco_baj}, o_signal, v);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL edge_drain got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch(input logic base);
    int t0;
    bit ok;
    for (int len = 1; len < 4; len++) begin
      i_signal = !base;
      repeat (len) step();
      i_signal = base;
      repeat (10) step();
      checks++;
      if (o_signal !== base) begin
        errors++;
        $display("FAIL glitch len=%0d got o_signal=%b required %b", len, o_signal, base);
      end
    end
    t0 = cyc;
    drive(!base);
    wait_cyc(t0 + 4);
    drive(base);
    wait_cyc(t0 + LAT);
    checks++;
    if (o_signal !== !base) begin
      errors++;
      $display("FAIL glitch_accept got o_signal=%b required %b", o_signal, !base);
    end
    drain(ok);
    checks++;
    if (!ok || o_signal !== base) begin
      errors++;
      $display("FAIL glitch_boundary got pending=%0d sig=%b required 0 %b", sb.size(), o_signal, base);
      sb.delete();
    end
  endtask

  task automatic test_square();
    bit ok;
    for (int i = 0; i < 8; i++) begin
      drive(!i_signal);
      repeat (24) step();
      checks++;
      if (o_sin_senal !== 1'b0 || o_signal !== i_signal) begin
        errors++;
        $display("FAIL square half=%0d got sin=%b sig=%b required 0 %b", i, o_sin_senal, o_signal, i_signal);
      end
      step();
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL square_drain got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int a, t0;
    bit ok;
    a = last_acc;
    wait_cyc(a + T - 1);
    checks++;
    if (o_sin_senal !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %b required 0", o_sin_senal);
    end
    wait_cyc(a + T);
    checks++;
    if (o_sin_senal !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set got %b required 1", o_sin_senal);
    end
    wait_cyc(a + 120);
    checks++;
    if (o_sin_senal !== 1'b1 || o_signal !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hold got sin=%b sig=%b required 1 0", o_sin_senal, o_signal);
    end
    t0 = cyc;
    drive(1'b1);
    wait_cyc(t0 + LAT - 1);
    checks++;
    if (o_sin_senal !== 1'b1) begin
      errors++;
      $display("FAIL timeout_before_edge got %b required 1", o_sin_senal);
    end
    wait_cyc(t0 + LAT);
    checks++;
    if (o_sin_senal !== 1'b0 || o_signal !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear got sin=%b sig=%b required 0 1", o_sin_senal, o_signal);
    end
    drain(ok);
  endtask

  task automatic test_reset_mid();
    int t0;
    bit ok;
    drive(1'b0);
    drain(ok);
    checks++;
    if (!ok || o_signal !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup got pending=%0d sig=%b required 0 0", sb.size(), o_signal);
      sb.delete();
    end
    t0 = cyc;
    i_signal = 1'b1;
    wait_cyc(t0 + 4);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_signal, o_flanco_sub, o_flanco_baj, o_sin_senal} !== 4'b0) begin
      errors++;
      $display("FAIL mid_async got %b required 0000", {o_signal, o_flanco_sub, o_flanco_baj, o_sin_senal});
    end
    repeat (2) step();
    reset_n = 1'b1;
    t0 = cyc;
    sb.push_back('{1'b1, t0 + LAT});
    wait_cyc(t0 + LAT - 1);
    checks++;
    if (o_signal !== 1'b0) begin
      errors++;
      $display("FAIL mid_requalify_early got o_signal=%b required 0", o_signal);
    end
    wait_cyc(t0 + LAT);
    checks++;
    if (o_signal !== 1'b1) begin
      errors++;
      $display("FAIL mid_requalify got o_signal=%b required 1", o_signal);
    end
    drain(ok);
  endtask

  initial begin
    test_reset();
    test_edge(1'b1);
    test_glitch(1'b1);
    test_edge(1'b0);
    test_glitch(1'b0);
    test_square();
    test_timeout();
    test_reset_mid();
    repeat (5) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard got %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
